// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// The operator codes are the same ones the ALU decodes.
package muldiv_sequencer_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [3:0] ALU_OP_MUL = 4'd3;
  localparam logic [3:0] ALU_OP_DIV = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } seq_state_t;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the pipeline and the multiply/divide sequencer.
interface muldiv_sequencer_if
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             inValid;
  logic             inReady;
  logic [3:0]       operator;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             flush;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result2;
  logic             busy;

  modport master (
    output inValid, operator, x, y, flush, outReady,
    input  inReady, outValid, result, result2, busy
  );

  modport slave (
    input  inValid, operator, x, y, flush, outReady,
    output inReady, outValid, result, result2, busy
  );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// MUL: {hi,lo} is the partial product, lo holds the remaining multiplier bits, b the multiplicand.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  always_comb begin
    sum     = hi + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
    hi_next = hi;
    lo_next = lo;
    if (is_div) begin
      // DIV: hi is the remainder, lo shifts the dividend out and the quotient in
      if (shifted >= {1'b0, b}) begin
        hi_next = shifted - {1'b0, b};
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted;
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = {1'b0, sum[WIDTH:1]};
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller: magnitudes are iterated WIDTH times, then sign-fixed.
//   state | meaning
//   IDLE  | waiting for a request
//   CALC  | one radix-2 iteration per cycle, WIDTH cycles
//   FIX   | sign correction, result registers loaded on exit
//   DONE  | result presented until the consumer takes it
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int CNT_W      = 6,
  parameter bit SIGNED_DIV = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);
  seq_state_t state, state_next;

  logic [CNT_W-1:0]   counter;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand_b;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result2_q;

  logic               accept;
  logic               op_mul;
  logic               op_div;
  logic               op_supported;
  logic               signed_op;
  logic               sx;
  logic               sy;
  logic [WIDTH-1:0]   abs_x;
  logic [WIDTH-1:0]   abs_y;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.inReady  = (state == IDLE) || ((state == DONE) && bus.outReady);
  assign bus.outValid = (state == DONE);
  assign bus.busy     = (state == CALC) || (state == FIX);
  assign bus.result   = result_q;
  assign bus.result2  = result2_q;

  // flush wins over a same-cycle request
  assign accept       = bus.inValid && bus.inReady && !bus.flush;
  assign op_mul       = (bus.operator == ALU_OP_MUL);
  assign op_div       = (bus.operator == ALU_OP_DIV);
  assign op_supported = op_mul || op_div;
  assign signed_op    = op_mul || (op_div && SIGNED_DIV);
  assign sx           = signed_op && bus.x[WIDTH-1];
  assign sy           = signed_op && bus.y[WIDTH-1];
  assign abs_x        = sx ? -bus.x : bus.x;
  assign abs_y        = sy ? -bus.y : bus.y;

  assign product      = {acc_hi[WIDTH-1:0], acc_lo};
  assign product_fix  = neg_lo ? -product : product;
  assign quot_fix     = neg_lo ? -acc_lo : acc_lo;
  assign rem_fix      = neg_hi ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .hi      (acc_hi),
    .lo      (acc_lo),
    .b       (operand_b),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = op_supported ? CALC : DONE;
      CALC: if (counter == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        if (accept)            state_next = op_supported ? CALC : DONE;
        else if (bus.outReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter   <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      result_q  <= '0;
      result2_q <= '0;
    end else begin
      if (accept && op_supported) begin
        counter   <= '0;
        is_div    <= op_div;
        neg_lo    <= sx ^ sy;
        neg_hi    <= op_div ? sx : (sx ^ sy);
        acc_hi    <= '0;
        acc_lo    <= op_div ? abs_x : abs_y;
        operand_b <= op_div ? abs_y : abs_x;
      end else if (state == CALC) begin
        counter <= counter + CNT_W'(1);
        acc_hi  <= step_hi;
        acc_lo  <= step_lo;
      end

      // results change only on completion, never from an aborted operation
      if (accept && !op_supported) begin
        result_q  <= '0;
        result2_q <= '0;
      end else if ((state == FIX) && !bus.flush) begin
        result_q  <= is_div ? quot_fix : product_fix[WIDTH-1:0];
        result2_q <= is_div ? rem_fix  : product_fix[2*WIDTH-1:WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: a reference model predicts each accepted request,
// a monitor compares every result transfer against the oldest prediction.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = '0;
  bit   rand_ready = 1'b0;

  muldiv_sequencer_if #(.WIDTH(32)) bus_if ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6), .SIGNED_DIV(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {result2, result}: MUL -> {hi, lo} of the signed product, DIV -> {remainder, quotient}
  function automatic logic [63:0] ref_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    if (op == 4'd3) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p;
    end else if (op == 4'd4) begin
      if (b == 0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    return 64'd0;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b, bit push);
    bit accepted = 1'b0;
    bus_if.inValid  = 1'b1;
    bus_if.operator = op;
    bus_if.x        = a;
    bus_if.y        = b;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus_if.inReady) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
    end
    if (accepted && push) exp_q.push_back(ref_model(op, a, b));
    #1;
    bus_if.inValid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_if.outValid && bus_if.outReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h_%h expected no output",
                 bus_if.result2, bus_if.result);
      end else begin
        last_exp = exp_q.pop_front();
        check("result", {32'd0, bus_if.result}, {32'd0, last_exp[31:0]});
        check("result2", {32'd0, bus_if.result2}, {32'd0, last_exp[63:32]});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus_if.outReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int edges, busy_cnt, seen_out, seen_busy;
    logic [3:0]  op;
    logic [31:0] a, b;

    rst_n           = 1'b0;
    bus_if.inValid  = 1'b0;
    bus_if.operator = 4'd0;
    bus_if.x        = '0;
    bus_if.y        = '0;
    bus_if.flush    = 1'b0;
    bus_if.outReady = 1'b1;
    #2;
    check("reset_inReady", 64'(bus_if.inReady), 64'd1);
    check("reset_outValid", 64'(bus_if.outValid), 64'd0);
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_outputs", {bus_if.result2, bus_if.result}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();

    // MUL 7 * -3: latency and busy width
    issue(ALU_OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1);
    edges = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.outValid) begin
        edges = k - 1;
        break;
      end
    end
    check("mul_latency_edges", 64'(edges), 64'd33);
    check("mul_busy_cycles", 64'(busy_cnt), 64'd33);
    drain();

    sync();
    issue(ALU_OP_DIV, 32'd100, 32'd7, 1'b1);
    issue(ALU_OP_DIV, 32'd5, 32'd0, 1'b1);
    drain();

    // backpressure then back-to-back issue
    sync();
    bus_if.outReady = 1'b0;
    issue(ALU_OP_DIV, 32'd1000, 32'd3, 1'b1);
    seen_out = 0;
    for (int k = 0; k < 60 && !seen_out; k++) begin
      @(negedge clk);
      if (bus_if.outValid) seen_out = 1;
    end
    check("bp_outValid_seen", 64'(seen_out), 64'd1);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clk);
      check("bp_outValid_hold", 64'(bus_if.outValid), 64'd1);
      check("bp_inReady_low", 64'(bus_if.inReady), 64'd0);
      check("bp_outputs_stable", {bus_if.result2, bus_if.result}, {32'd1, 32'd333});
    end
    sync();
    bus_if.outReady = 1'b1;
    issue(ALU_OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b1);
    @(negedge clk);
    check("b2b_busy_no_bubble", 64'(bus_if.busy), 64'd1);
    drain();

    // flush on CALC cycle 10 of a DIV
    sync();
    issue(ALU_OP_DIV, 32'd77, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus_if.flush = 1'b1;
    @(posedge clk);
    #1 bus_if.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(bus_if.busy), 64'd0);
    check("flush_inReady", 64'(bus_if.inReady), 64'd1);
    seen_out = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_if.outValid) seen_out = 1;
    end
    check("flush_no_outValid", 64'(seen_out), 64'd0);
    check("flush_outputs_kept", {bus_if.result2, bus_if.result}, last_exp);

    // asynchronous reset mid-CALC
    sync();
    issue(ALU_OP_MUL, 32'h1234, 32'h5678, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {bus_if.result2, bus_if.result}, 64'd0);
    check("rst_mid_busy", 64'(bus_if.busy), 64'd0);
    check("rst_mid_outValid", 64'(bus_if.outValid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_inReady", 64'(bus_if.inReady), 64'd1);
    sync();
    issue(ALU_OP_MUL, 32'd3, 32'd4, 1'b1);
    drain();

    // unsupported operator
    sync();
    issue(4'd5, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    @(negedge clk);
    check("unsup_outValid_1cycle", 64'(bus_if.outValid), 64'd1);
    check("unsup_busy", 64'(bus_if.busy), 64'd0);
    drain();

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = ALU_OP_MUL;
        4, 5, 6, 7: op = ALU_OP_DIV;
        8:          op = 4'd5;
        default:    op = 4'd0;
      endcase
      a = $urandom();
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 255);
        3:       b = 32'h8000_0000;
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      issue(op, a, b, 1'b1);
    end
    rand_ready = 1'b0;
    #2 bus_if.outReady = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
